// File: rtl/sar_sequencer.sv
// SAR ADC conversion sequencer: sample, MSB->LSB bit trials, result handshake.
// Optional macro SAR_CONT_EN: DONE with VACK and VSTART restarts sampling directly.
module sar_sequencer #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             VRESET_N,
  input  logic             VSTART,
  input  logic             VCOMP,
  input  logic             VACK,
  output logic             VSAMPLE,
  output logic             VBITRESET,
  output logic [NBITS-1:0] VENABLE,
  output logic [NBITS-1:0] VDAC,
  output logic [NBITS-1:0] VDATA,
  output logic             VVALID,
  output logic             VBUSY
);
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ? SAMPLE_CYCLES : SETTLE_CYCLES + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NBITS);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] onehot;
  logic [NBITS-1:0] res;

  assign onehot = NBITS'(1) << bit_q;

  always_ff @(posedge CLK) begin
    if (!VRESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    data_d  = data_q;
    res     = VCOMP ? (acc_q | onehot) : (acc_q & ~onehot);
    case (state_q)
      S_IDLE: begin
        if (VSTART) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d = S_CONV;
          cnt_d   = '0;
          bit_d   = BW'(NBITS - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONV: begin
        // VCOMP only matters on the final settle cycle of each bit
        if (cnt_q == CW'(SETTLE_CYCLES)) begin
          cnt_d = '0;
          acc_d = res;
          if (bit_q == '0) begin
            state_d = S_DONE;
            data_d  = res;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (VACK) begin
`ifdef SAR_CONT_EN
          if (VSTART) begin
            state_d = S_SAMPLE;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so they change cleanly after each edge
  always_comb begin
    VSAMPLE   = (state_q == S_SAMPLE);
    VBITRESET = (state_q == S_IDLE) || (state_q == S_SAMPLE);
    VBUSY     = (state_q == S_SAMPLE) || (state_q == S_CONV);
    VVALID    = (state_q == S_DONE);
    VENABLE   = (state_q == S_CONV) ? onehot : '0;
    VDAC      = (state_q == S_CONV) ? (acc_q | onehot) : '0;
    VDATA     = data_q;
  end
endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with default parameters and a comparator model.
module tb_sar_sequencer;
  logic       CLK, VRESET_N, VSTART, VCOMP, VACK;
  logic       VSAMPLE, VBITRESET, VVALID, VBUSY;
  logic [7:0] VENABLE, VDAC, VDATA;
  logic [7:0] vin;
  int         cmode;  // 0: tie low, 1: tie high, 2: compare vin against VDAC
  int         checks, failures;
  logic [7:0] seq [8];
  logic       vv_seen;

  sar_sequencer dut (
    .CLK(CLK), .VRESET_N(VRESET_N), .VSTART(VSTART), .VCOMP(VCOMP), .VACK(VACK),
    .VSAMPLE(VSAMPLE), .VBITRESET(VBITRESET), .VENABLE(VENABLE), .VDAC(VDAC),
    .VDATA(VDATA), .VVALID(VVALID), .VBUSY(VBUSY)
  );

  assign VCOMP = (cmode == 2) ? (vin >= VDAC) : (cmode == 1);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples VSTART at the next edge; returns just after that edge (cycle 1)
  task automatic start_conv();
    VSTART = 1'b1;
    step();
    VSTART = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    VRESET_N = 1'b0; VSTART = 1'b1; VACK = 1'b0; vin = 8'h00; cmode = 0;

    // reset held 3 cycles with VSTART high
    repeat (3) step();
    chk("rst_sample", VSAMPLE, 1'b0);
    chk("rst_bitreset", VBITRESET, 1'b1);
    chk("rst_enable", VENABLE, 8'h00);
    chk("rst_dac", VDAC, 8'h00);
    chk("rst_data", VDATA, 8'h00);
    chk("rst_valid", VVALID, 1'b0);
    chk("rst_busy", VBUSY, 1'b0);
    VRESET_N = 1'b1; VSTART = 1'b0;
    step();
    chk("idle_busy", VBUSY, 1'b0);

    // vin = 0xA5 conversion with trial sequence
    vin = 8'hA5; cmode = 2;
    start_conv();
    chk("a5_sample_c1", VSAMPLE, 1'b1);
    chk("a5_busy_c1", VBUSY, 1'b1);
    chk("a5_dac_c1", VDAC, 8'h00);
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 3) chk("a5_sample_c4", VSAMPLE, 1'b1);
      if (e == 4) begin
        chk("a5_sample_c5", VSAMPLE, 1'b0);
        chk("a5_bitreset_c5", VBITRESET, 1'b0);
      end
      if (e >= 4 && e <= 19) begin
        chk($sformatf("a5_dac_e%0d", e), VDAC, seq[(e-4)/2]);
        chk($sformatf("a5_en_e%0d", e), VENABLE, 8'h80 >> ((e-4)/2));
      end
      if (e == 19) chk("a5_valid_c20", VVALID, 1'b0);
    end
    chk("a5_valid_c21", VVALID, 1'b1);
    chk("a5_data_c21", VDATA, 8'hA5);
    chk("a5_busy_c21", VBUSY, 1'b0);
    chk("a5_enable_c21", VENABLE, 8'h00);

    // hold without ack while pulsing VSTART
    for (int k = 0; k < 10; k++) begin
      VSTART = k[0];
      step();
      chk("hold_valid", VVALID, 1'b1);
      chk("hold_data", VDATA, 8'hA5);
      chk("hold_sample", VSAMPLE, 1'b0);
    end
    VSTART = 1'b0; VACK = 1'b1;
    step();
    VACK = 1'b0;
    chk("ack_valid", VVALID, 1'b0);
    chk("ack_data_kept", VDATA, 8'hA5);
    chk("ack_bitreset", VBITRESET, 1'b1);

    // comparator tied high -> all ones
    cmode = 1;
    start_conv();
    repeat (19) step();
    chk("ones_valid_c20", VVALID, 1'b0);
    step();
    chk("ones_valid_c21", VVALID, 1'b1);
    chk("ones_data", VDATA, 8'hFF);
    VACK = 1'b1; step(); VACK = 1'b0;

    // reset mid-conversion clears everything, no result appears
    start_conv();
    repeat (9) step();
    chk("mid_busy", VBUSY, 1'b1);
    VRESET_N = 1'b0;
    step();
    VRESET_N = 1'b1;
    chk("mrst_busy", VBUSY, 1'b0);
    chk("mrst_enable", VENABLE, 8'h00);
    chk("mrst_dac", VDAC, 8'h00);
    chk("mrst_data", VDATA, 8'h00);
    vv_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (VVALID !== 1'b0) vv_seen = 1'b1;
    end
    chk("mrst_valid_never", vv_seen, 1'b0);

    // comparator tied low -> zero
    cmode = 0;
    start_conv();
    repeat (19) step();
    chk("zeros_valid_c20", VVALID, 1'b0);
    step();
    chk("zeros_valid_c21", VVALID, 1'b1);
    chk("zeros_data", VDATA, 8'h00);

    // VSTART with VACK in DONE
    VSTART = 1'b1; VACK = 1'b1;
    step();
    VACK = 1'b0;
`ifdef SAR_CONT_EN
    VSTART = 1'b0;
    chk("cont_sample", VSAMPLE, 1'b1);
    chk("cont_valid", VVALID, 1'b0);
`else
    chk("ack_start_sample", VSAMPLE, 1'b0);
    chk("ack_start_valid", VVALID, 1'b0);
    step();
    VSTART = 1'b0;
    chk("restart_sample", VSAMPLE, 1'b1);
`endif
    chk("restart_busy", VBUSY, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
